// File: rtl/ypb_port_arbiter.sv
// ypb_port_arbiter
// Shares a single OBI-style memory port between NumReq YPB requesters.
// Requests are picked round-robin, a request that is not granted at once is
// held until granted, and the issue order of outstanding requests is kept in
// a small routing FIFO so that in-order responses reach the right requester.
module ypb_port_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0]               req_we_i,
  input  logic [NumReq*DataWidth/8-1:0]   req_be_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  output logic [NumReq-1:0]               rsp_valid_o,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic                            mem_we_o,
  output logic [DataWidth/8-1:0]          mem_be_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  input  logic                            mem_rvalid_i,
  input  logic [DataWidth-1:0]            mem_rdata_i,
  input  logic                            mem_err_i,
  output logic                            proto_err_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Control state
  state_e            state_q, state_d;
  logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              proto_err_q, proto_err_d;

  // Routing FIFO storage (requester index per outstanding transaction)
  logic [IdxW-1:0]   fifo_q [MaxOutstanding];

  // Combinational helpers
  logic              any_valid;
  logic [IdxW-1:0]   arb_idx;
  logic [IdxW-1:0]   cand;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   head_idx;
  logic              issue;
  logic              handshake;
  logic              pop;
  logic [AddrWidth-1:0] sel_addr;
  logic              sel_we;
  logic [BeWidth-1:0] sel_be;
  logic [DataWidth-1:0] sel_wdata;

  // Successor of a requester index, wrapping at NumReq.
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (idx == LastIdx) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // Routing FIFO pointer increment; a single-entry FIFO keeps its pointer at 0.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (MaxOutstanding == 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Valid bit of the requester addressed by idx.
  function automatic logic valid_at(input logic [NumReq-1:0] v, input logic [IdxW-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (idx == IdxW'(i)) begin
        hit = v[i];
      end
    end
    return hit;
  endfunction

  // One-hot requester vector for idx.
  function automatic logic [NumReq-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [NumReq-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (idx == IdxW'(i)) begin
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  assign head_idx = fifo_q[rd_ptr_q];

  // Arbitration, downstream request, response routing and next-state logic.
  always_comb begin
    // Round-robin search starting at rr_ptr
    any_valid = 1'b0;
    arb_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!any_valid && valid_at(req_valid_i, cand)) begin
        any_valid = 1'b1;
        arb_idx   = cand;
      end
      cand = next_idx(cand);
    end

    // A held request is presented regardless of the outstanding count; a new
    // one only when a routing slot is free at the start of the cycle.
    sel_idx   = (state_q == LOCKED) ? lock_idx_q : arb_idx;
    issue     = rst_ni && ((state_q == LOCKED) || (any_valid && (count_q < CntMax)));
    handshake = issue && mem_gnt_i;
    pop       = rst_ni && mem_rvalid_i && (count_q != '0);

    // Payload mux
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_addr  = req_addr_i[i*AddrWidth +: AddrWidth];
        sel_we    = req_we_i[i];
        sel_be    = req_be_i[i*BeWidth +: BeWidth];
        sel_wdata = req_wdata_i[i*DataWidth +: DataWidth];
      end
    end

    mem_req_o   = issue;
    mem_addr_o  = issue ? sel_addr  : '0;
    mem_we_o    = issue ? sel_we    : 1'b0;
    mem_be_o    = issue ? sel_be    : '0;
    mem_wdata_o = issue ? sel_wdata : '0;
    req_ready_o = handshake ? onehot(sel_idx) : '0;

    rsp_valid_o = pop ? onehot(head_idx) : '0;
    rsp_rdata_o = pop ? mem_rdata_i : '0;
    rsp_err_o   = pop ? mem_err_i : 1'b0;
    proto_err_o = rst_ni && proto_err_q;

    // Next state
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      IDLE: begin
        if (issue && !mem_gnt_i) begin
          state_d    = LOCKED;
          lock_idx_d = arb_idx;
        end
      end
      LOCKED: begin
        if (mem_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rr_ptr_d    = handshake ? next_idx(sel_idx) : rr_ptr_q;
    wr_ptr_d    = handshake ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    proto_err_d = proto_err_q || (mem_rvalid_i && (count_q == '0));

    unique case ({handshake, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Routing FIFO write: record the granted requester on each handshake.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      fifo_q[wr_ptr_q] <= sel_idx;
    end
  end

endmodule

// File: tb/tb_ypb_port_arbiter.sv
// Testbench for ypb_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_ypb_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_we;
  logic [NR*BW-1:0]  req_be;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_gnt;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [BW-1:0]     mem_be;
  logic [DW-1:0]     mem_wdata;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  logic              mem_err;
  logic              proto_err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_held;
  int m_rr;
  int m_q[$];
  bit m_perr;

  always #5 clk = ~clk;

  ypb_port_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .proto_err_o(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_addr   = '0;
    req_we     = '0;
    req_be     = '0;
    req_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic we, input logic [BW-1:0] be, input logic [DW-1:0] wd);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_be[i*BW +: BW]     = be;
    req_wdata[i*DW +: DW]  = wd;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n  = 1'b1;
    m_held = -1;
    m_rr   = 0;
    m_q.delete();
    m_perr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = '1;
    mem_err    = 1'b1;
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, 32'h1000 + 32'(i) * 32'h10, 1'b1, 4'hF, 32'hCAFE0000 + 32'(i));
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0 ||
          rsp_err !== 1'b0 || mem_addr !== '0 || mem_we !== 1'b0 || mem_be !== '0 ||
          mem_wdata !== '0 || proto_err !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_outputs c%0d: req=%b rdy=%b rsp=%b rdata=%h err=%b addr=%h we=%b be=%h wd=%h perr=%b, expected all 0",
                 c, mem_req, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_be, mem_wdata, proto_err);
      end
      tick();
    end
    rst_n      = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin
      n_errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, expected req=1 addr=00001000", mem_req, mem_addr);
    end
    n_checks++;
    if (req_ready !== '0 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_first_ready: rdy=%b perr=%b, expected 0000 and 0", req_ready, proto_err);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_rsp;
    logic [AW-1:0] exp_addr;
    apply_reset();
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, 32'h2000 + 32'(i) * 32'h4, 1'b0, 4'hF, 32'(i));
    mem_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mem_rvalid = (k >= 1);
      mem_rdata  = 32'h111 * 32'(k);
      mem_err    = 1'b0;
      #1;
      exp_rdy  = 4'b0001 << (k % NR);
      exp_rsp  = (k >= 1) ? (4'b0001 << ((k - 1) % NR)) : 4'b0000;
      exp_addr = 32'h2000 + 32'(k % NR) * 32'h4;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL rr_grant k%0d: rdy=%b expected %b", k, req_ready, exp_rdy);
      end
      n_checks++;
      if (mem_addr !== exp_addr) begin
        n_errors++;
        $display("FAIL rr_addr k%0d: addr=%h expected %h", k, mem_addr, exp_addr);
      end
      n_checks++;
      if (rsp_valid !== exp_rsp) begin
        n_errors++;
        $display("FAIL rr_rsp k%0d: rsp=%b expected %b", k, rsp_valid, exp_rsp);
      end
      n_checks++;
      if (rsp_rdata !== ((k >= 1) ? 32'h111 * 32'(k) : 32'h0)) begin
        n_errors++;
        $display("FAIL rr_rdata k%0d: rdata=%h expected %h", k, rsp_rdata, (k >= 1) ? 32'h111 * 32'(k) : 32'h0);
      end
      tick();
    end
  endtask

  task automatic test_lock_hold();
    apply_reset();
    set_req(2, 1'b1, 32'h80, 1'b1, 4'hF, 32'hDEAD);
    mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_req(0, 1'b1, 32'h40, 1'b0, 4'h3, 32'h0);
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h80 || req_ready !== '0) begin
        n_errors++;
        $display("FAIL lock_hold c%0d: req=%b addr=%h rdy=%b expected 1 00000080 0000", c, mem_req, mem_addr, req_ready);
      end
      n_checks++;
      if (mem_we !== 1'b1 || mem_be !== 4'hF || mem_wdata !== 32'hDEAD) begin
        n_errors++;
        $display("FAIL lock_payload c%0d: we=%b be=%h wd=%h expected 1 f 0000dead", c, mem_we, mem_be, mem_wdata);
      end
      tick();
    end
    mem_gnt = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100 || mem_addr !== 32'h80) begin
      n_errors++;
      $display("FAIL lock_grant: rdy=%b addr=%h expected 0100 00000080", req_ready, mem_addr);
    end
    tick();
    set_req(2, 1'b0, '0, 1'b0, '0, '0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001 || mem_addr !== 32'h40 || mem_be !== 4'h3) begin
      n_errors++;
      $display("FAIL lock_next: rdy=%b addr=%h be=%h expected 0001 00000040 3", req_ready, mem_addr, mem_be);
    end
    tick();
  endtask

  task automatic test_full_stall();
    apply_reset();
    set_req(1, 1'b1, 32'h300, 1'b0, 4'hF, 32'h0);
    mem_gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
        n_errors++;
        $display("FAIL stall_issue c%0d: rdy=%b expected 0010", c, req_ready);
      end
      tick();
    end
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || req_ready !== '0 || mem_addr !== '0) begin
      n_errors++;
      $display("FAIL stall_full: req=%b rdy=%b addr=%h expected 0 0000 0", mem_req, req_ready, mem_addr);
    end
    tick();
    mem_rvalid = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || rsp_valid !== 4'b0010) begin
      n_errors++;
      $display("FAIL stall_pop_cycle: req=%b rsp=%b expected 0 0010", mem_req, rsp_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || req_ready !== 4'b0010) begin
      n_errors++;
      $display("FAIL stall_resume: req=%b rdy=%b expected 1 0010", mem_req, req_ready);
    end
    tick();
  endtask

  task automatic test_routing();
    apply_reset();
    set_req(1, 1'b1, 32'h100, 1'b0, 4'hF, '0);
    mem_gnt = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_errors++;
      $display("FAIL route_grant1: rdy=%b expected 0010", req_ready);
    end
    tick();
    set_req(1, 1'b0, '0, 1'b0, '0, '0);
    set_req(3, 1'b1, 32'h300, 1'b0, 4'hF, '0);
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_errors++;
      $display("FAIL route_grant3: rdy=%b expected 1000", req_ready);
    end
    tick();
    set_req(3, 1'b0, '0, 1'b0, '0, '0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA;
    mem_err    = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hAAAA || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL route_rsp1: rsp=%b rdata=%h err=%b expected 0010 0000aaaa 0", rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
    mem_rdata = 32'h5555;
    mem_err   = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b1000 || rsp_rdata !== 32'h5555 || rsp_err !== 1'b1) begin
      n_errors++;
      $display("FAIL route_rsp3: rsp=%b rdata=%h err=%b expected 1000 00005555 1", rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
    mem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL route_idle: rsp=%b rdata=%h err=%b perr=%b expected all 0", rsp_valid, rsp_rdata, rsp_err, proto_err);
    end
    tick();
  endtask

  task automatic test_spurious();
    apply_reset();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234;
    mem_err    = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL spur_cycle: rsp=%b rdata=%h err=%b perr=%b expected 0 0 0 0", rsp_valid, rsp_rdata, rsp_err, proto_err);
    end
    tick();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (proto_err !== 1'b1 || rsp_valid !== '0) begin
        n_errors++;
        $display("FAIL spur_sticky c%0d: perr=%b rsp=%b expected 1 0000", c, proto_err, rsp_valid);
      end
      tick();
    end
    set_req(0, 1'b1, 32'h10, 1'b0, 4'hF, '0);
    mem_gnt = 1'b1;
    #1;
    tick();
    set_req(0, 1'b0, '0, 1'b0, '0, '0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0001 || proto_err !== 1'b1) begin
      n_errors++;
      $display("FAIL spur_after_txn: rsp=%b perr=%b expected 0001 1", rsp_valid, proto_err);
    end
    tick();
    apply_reset();
    #1;
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_errors++;
      $display("FAIL spur_reset_clear: perr=%b expected 0", proto_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(2, 1'b1, 32'h220, 1'b0, 4'hF, '0);
    mem_gnt = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_errors++;
      $display("FAIL midrst_grant: rdy=%b expected 0100", req_ready);
    end
    tick();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== '0) begin
      n_errors++;
      $display("FAIL midrst_rsp: rsp=%b expected 0000", rsp_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_perr: perr=%b expected 1", proto_err);
    end
    tick();
  endtask

  task automatic test_random(input int n_cycles);
    bit            pend[NR];
    bit            e_req;
    bit            e_pop;
    int            e_idx;
    int            c_idx;
    logic [NR-1:0] e_rdy;
    logic [NR-1:0] e_rsp;
    logic [AW+1+BW+DW-1:0] e_pay;
    apply_reset();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    for (int c = 0; c < n_cycles; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            set_req(i, 1'b1, $urandom, 1'($urandom), 4'($urandom), $urandom);
          end else begin
            set_req(i, 1'b0, '0, 1'b0, '0, '0);
          end
        end
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata  = $urandom;
      mem_err    = 1'($urandom);

      e_req = 1'b0;
      e_idx = -1;
      if (m_held >= 0) begin
        e_req = 1'b1;
        e_idx = m_held;
      end else if (m_q.size() < MO) begin
        for (int k = 0; k < NR; k++) begin
          c_idx = (m_rr + k) % NR;
          if (!e_req && ((req_valid >> c_idx) & 4'b0001) != 4'b0000) begin
            e_req = 1'b1;
            e_idx = c_idx;
          end
        end
      end
      e_pop = mem_rvalid && (m_q.size() > 0);
      e_rdy = (e_req && mem_gnt) ? (4'b0001 << e_idx) : 4'b0000;
      e_rsp = e_pop ? (4'b0001 << m_q[0]) : 4'b0000;
      e_pay = '0;
      if (e_req)
        e_pay = {req_addr[e_idx*AW +: AW], req_we[e_idx], req_be[e_idx*BW +: BW], req_wdata[e_idx*DW +: DW]};

      #1;
      n_checks++;
      if (mem_req !== e_req || req_ready !== e_rdy) begin
        n_errors++;
        $display("FAIL rand_req c%0d: req=%b rdy=%b expected %b %b", c, mem_req, req_ready, e_req, e_rdy);
      end
      n_checks++;
      if ({mem_addr, mem_we, mem_be, mem_wdata} !== e_pay) begin
        n_errors++;
        $display("FAIL rand_payload c%0d: got %h expected %h", c, {mem_addr, mem_we, mem_be, mem_wdata}, e_pay);
      end
      n_checks++;
      if (rsp_valid !== e_rsp || rsp_rdata !== (e_pop ? mem_rdata : 32'h0) || rsp_err !== (e_pop && mem_err)) begin
        n_errors++;
        $display("FAIL rand_rsp c%0d: rsp=%b rdata=%h err=%b expected %b %h %b", c, rsp_valid, rsp_rdata, rsp_err,
                 e_rsp, e_pop ? mem_rdata : 32'h0, e_pop && mem_err);
      end
      n_checks++;
      if (proto_err !== m_perr) begin
        n_errors++;
        $display("FAIL rand_perr c%0d: perr=%b expected %b", c, proto_err, m_perr);
      end

      if (mem_rvalid && m_q.size() == 0) m_perr = 1'b1;
      if (e_pop) void'(m_q.pop_front());
      if (e_req && mem_gnt) begin
        m_q.push_back(e_idx);
        m_rr    = (e_idx + 1) % NR;
        m_held  = -1;
        pend[e_idx] = 1'b0;
      end else if (e_req) begin
        m_held = e_idx;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_full_stall();
    test_routing();
    test_spurious();
    test_reset_mid();
    test_random(1500);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ypb_port_arbiter.md
# ypb_port_arbiter

Shares one OBI-style memory port between `NumReq` YPB requesters (fetch, load, store, AMO, PTW, Zcmt) when the design is built pipeline-only with no cache subsystem. It sits between the pipeline's YPB channels and the NoC adapter's single request port. Requests are arbitrated round-robin and a pending request is held stable until it is granted. Issue order of up to `MaxOutstanding` requests is recorded so that in-order responses go back to the requester that issued them.

## Interface
Parameters:
- `NumReq`, 4, number of requesters; index 0 wins the first arbitration after reset.
- `AddrWidth`, 32, address width.
- `DataWidth`, 32, data width; `be` is `DataWidth/8` bits.
- `MaxOutstanding`, 2, depth of the routing FIFO (power of two, ≥1).

Ports (vectors indexed by requester; packed buses are `NumReq` slices):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, reset is synchronous and active-low.
- `req_valid_i`  in  NumReq  request valid per requester.
- `req_ready_o`  out  NumReq  request accepted this cycle.
- `req_addr_i`  in  NumReq*AddrWidth  address.
- `req_we_i`  in  NumReq  write enable.
- `req_be_i`  in  NumReq*DataWidth/8  byte enables.
- `req_wdata_i`  in  NumReq*DataWidth  write data.
- `rsp_valid_o`  out  NumReq  one-hot response strobe.
- `rsp_rdata_o`  out  DataWidth  response data, shared by all requesters.
- `rsp_err_o`  out  1  response error, qualified by `rsp_valid_o`.
- `mem_req_o`  out  1  downstream request.
- `mem_gnt_i`  in  1  downstream grant.
- `mem_addr_o`  out  AddrWidth  downstream address.
- `mem_we_o`  out  1  downstream write enable.
- `mem_be_o`  out  DataWidth/8  downstream byte enables.
- `mem_wdata_o`  out  DataWidth  downstream write data.
- `mem_rvalid_i`  in  1  downstream response valid.
- `mem_rdata_i`  in  DataWidth  downstream response data.
- `mem_err_i`  in  1  downstream response error.
- `proto_err_o`  out  1  sticky flag: a response arrived with no transaction outstanding.

## Operation
- FSM states:
  - **IDLE**: no request is held. If any `req_valid_i` is set and `count < MaxOutstanding`, select the winner combinationally: the first valid index at or after `rr_ptr`, wrapping modulo `NumReq`. Drive `mem_req_o=1` and the winner's payload in the same cycle.
    - If `mem_gnt_i` is high in that cycle, the handshake completes and the FSM stays in IDLE.
    - Otherwise register the winner in `lock_idx` and go to **LOCKED**.
  - **LOCKED**: drive `mem_req_o=1` with the payload of `lock_idx`; no re-arbitration occurs. On `mem_gnt_i`, return to IDLE.
- Handshake completes when `mem_req_o && mem_gnt_i`. That cycle:
  - `req_ready_o[winner]=1`; all other `req_ready_o` bits are 0.
  - Push the winner index into the routing FIFO.
  - Set `rr_ptr = (winner+1) mod NumReq`.
- Requesters must hold `valid` and payload stable until `ready`. Dropping `valid` while in LOCKED is a requester protocol violation; the arbiter keeps presenting the request.
- Outstanding limit: when `count == MaxOutstanding`, `mem_req_o=0` in IDLE. A pop in the same cycle does not free a slot for issue (no bypass). LOCKED is only entered with a free slot, so it is never affected.
- Responses:
  - On `mem_rvalid_i` with `count>0`: pulse `rsp_valid_o[fifo_head]=1`, pass `rsp_rdata_o=mem_rdata_i` and `rsp_err_o=mem_err_i` through combinationally, and pop the FIFO.
  - On `mem_rvalid_i` with `count==0`: set `proto_err_o` until reset. No response strobe is driven.
- Simultaneous push and pop: `count` is unchanged and the FIFO pointers wrap modulo `MaxOutstanding`.
- Outputs when nothing is driven: `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are 0 while `mem_req_o=0`. `rsp_rdata_o` and `rsp_err_o` are 0 while no `rsp_valid_o` bit is set.

## Timing
- Reset values: state=IDLE, `rr_ptr=0`, `count=0`, FIFO pointers 0, `proto_err_o=0`. All outputs are 0.
- Reset asserted mid-transaction clears state on the next clock edge. Any outstanding response then arriving sets `proto_err_o`.
- Request path is combinational from `req_valid_i` to `mem_req_o`: zero cycles when nothing is held or full.
- Grant path is combinational from `mem_gnt_i` to `req_ready_o`.
- Response path is combinational from `mem_rvalid_i` to `rsp_valid_o`; response latency is 0.
- Maximum throughput is one issue per cycle while `count < MaxOutstanding`.

## Test plan
- **Reset:** `rst_ni=0` for 2 cycles with all requesters valid. Required: all outputs 0. First cycle after reset: `mem_req_o=1` with requester 0's address.
- **Round-robin, NumReq=4:** all four valid continuously, `mem_gnt_i=1`, responses returned every cycle. Required grant order 0,1,2,3,0. `rsp_valid_o` returns 0001,0010,0100,1000,0001 one cycle after each grant.
- **Lock hold:** requester 2 valid with `addr=0x80`, `mem_gnt_i=0` for 3 cycles, requester 0 becomes valid in cycle 1. Required: `mem_addr_o=0x80` in all cycles. Requester 2 is granted on the first `mem_gnt_i=1`; requester 0 is granted next.
- **Full stall:** MaxOutstanding=2, two grants issued, no `mem_rvalid_i`. Required: `mem_req_o=0`. In the cycle `rvalid` pops, `mem_req_o` stays 0; it rises the following cycle.
- **Routing:** grant requester 1 then requester 3; send responses `rdata=0xAAAA` then `0x5555` with `err=1`. Required: `rsp_valid_o[1]` with `0xAAAA`, then `rsp_valid_o[3]` with `0x5555` and `rsp_err_o=1`.
- **Spurious response:** `mem_rvalid_i=1` with `count=0`. Required: `proto_err_o` goes to 1 and stays 1 until reset; all `rsp_valid_o` bits stay 0.
